// File: rtl/cic_interp_pkg.sv
// Shared CIC helpers: internal width and rate-dependent gain-normalising shift.
// Latency: none (elaboration-time and combinational functions only).
// Backpressure: not applicable.
package cic_interp_pkg;

    localparam int CIC_BW            = 16;
    localparam int CIC_N             = 4;
    localparam int CIC_LOG2_MAX_RATE = 7;

    typedef logic [7:0] rate_t;
    typedef logic [5:0] shift_t;

    // Internal accumulator width: input width plus worst-case CIC bit growth.
    function automatic int cic_width(input int bw, input int n, input int log2_max_rate);
        return bw + (n - 1) * log2_max_rate;
    endfunction

    // Smallest s with 2^s >= rate^(n-1); counts powers of two strictly below the gain.
    function automatic shift_t cic_shift(input rate_t rate, input int n);
        logic [63:0] gain;
        shift_t      s;
        gain = 64'd1;
        for (int i = 1; i < n; i++) begin
            gain = gain * {56'd0, rate};
        end
        s = 6'd0;
        for (int b = 0; b < 63; b++) begin
            if ((64'd1 << b) < gain) begin
                s = s + 6'd1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/cic_int_shifter.sv
// Gain normaliser: maps rate to shift amount and slices bw bits out of the last integrator.
// Latency: combinational, no registers.
// Backpressure: none; output follows inputs every cycle.
module cic_int_shifter
    import cic_interp_pkg::*;
#(
    parameter int bw = CIC_BW,
    parameter int N  = CIC_N,
    parameter int W  = cic_width(CIC_BW, CIC_N, CIC_LOG2_MAX_RATE)
) (
    input  logic [7:0]    rate,
    input  logic [W-1:0]  integ_top,
    output logic [bw-1:0] shifted
);

    shift_t shift;

    // Truncating slice integ_top[shift+bw-1 : shift]; upper bits beyond bw are dropped.
    always_comb begin
        shift   = cic_shift(rate, N);
        shifted = bw'(integ_top >> shift);
    end

endmodule

// File: rtl/cic_interp.sv
// CIC interpolator: N combs at strobe_in rate, zero-stuff hold, N integrators at strobe_out rate.
// Latency: sample at strobe_in k enters hold at strobe_in k+N, reaches signal_out N strobe_outs + 1 clock later.
// Backpressure: none; strobes are externally paced and never stalled.
module cic_interp
    import cic_interp_pkg::*;
#(
    parameter int bw               = CIC_BW,
    parameter int N                = CIC_N,
    parameter int log2_of_max_rate = CIC_LOG2_MAX_RATE
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    rate,
    input  logic          strobe_in,
    input  logic          strobe_out,
    input  logic [bw-1:0] signal_in,
    output logic [bw-1:0] signal_out
);

    localparam int W = cic_width(bw, N, log2_of_max_rate);

    logic          clear;
    logic [W-1:0]  x_ext;
    logic [W-1:0]  comb_in  [N];
    logic [W-1:0]  comb_q   [N];
    logic [W-1:0]  integ_in [N];
    logic [W-1:0]  integ_q  [N];
    logic [W-1:0]  hold;
    logic [bw-1:0] shifted;

    // enable low behaves exactly like reset: all state is held at zero.
    assign clear = reset || !enable;
    assign x_ext = {{(W-bw){signal_in[bw-1]}}, signal_in};

    for (genvar k = 0; k < N; k++) begin : g_comb
        logic [W-1:0] diff_r;
        logic [W-1:0] comb_r;

        if (k == 0) begin : g_src_in
            assign comb_in[k] = x_ext;
        end else begin : g_src_prev
            assign comb_in[k] = comb_q[k-1];
        end

        // Comb stage: first difference of the previous stage, advanced on each low-rate strobe.
        always_ff @(posedge clock) begin
            if (clear) begin
                diff_r <= '0;
                comb_r <= '0;
            end else if (strobe_in) begin
                diff_r <= comb_in[k];
                comb_r <= comb_in[k] - diff_r;
            end
        end

        assign comb_q[k] = comb_r;
    end

    // Zero-stuffing hold: a new comb value takes priority over the post-use clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            hold <= '0;
        end else if (strobe_in) begin
            hold <= comb_q[N-1];
        end else if (strobe_out) begin
            hold <= '0;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_integ
        logic [W-1:0] acc_r;

        if (k == 0) begin : g_src_hold
            assign integ_in[k] = hold;
        end else begin : g_src_prev
            assign integ_in[k] = integ_q[k-1];
        end

        // Integrator stage: running sum of the previous stage, advanced on each high-rate strobe.
        always_ff @(posedge clock) begin
            if (clear) begin
                acc_r <= '0;
            end else if (strobe_out) begin
                acc_r <= acc_r + integ_in[k];
            end
        end

        assign integ_q[k] = acc_r;
    end

    cic_int_shifter #(
        .bw (bw),
        .N  (N),
        .W  (W)
    ) u_shifter (
        .rate      (rate),
        .integ_top (integ_q[N-1]),
        .shifted   (shifted)
    );

    // Output register: re-samples the normalised integrator every clock.
    always_ff @(posedge clock) begin
        if (clear) begin
            signal_out <= '0;
        end else begin
            signal_out <= shifted;
        end
    end

endmodule

// File: doc/cic_interp.md
# cic_interp

Multi-stage CIC interpolator for the transmit DSP chain: takes baseband samples at the low rate (one per `strobe_in`), runs them through N comb stages, zero-stuffs up to the high rate (one per `strobe_out`), and integrates through N integrator stages. It is the transmit-side counterpart of the receive CIC decimator and sits between the halfband/interpolation front end and the DUC mixer. A rate-dependent right shift normalises the CIC gain of rate^(N-1) back to unity (within one bit).

## Interface
- `bw`, 16, sample width in and out (two's complement)
- `N`, 4, number of comb stages and number of integrator stages
- `log2_of_max_rate`, 7, log2 of the largest supported interpolation rate; internal width W = bw + (N-1)*log2_of_max_rate

- `clock`  in  1  single clock domain
- `reset`  in  1  synchronous, active-high; clears all state
- `enable`  in  1  low = hold all state at zero (same effect as reset)
- `rate`  in  8  interpolation ratio R, 1 ≤ R ≤ 2^log2_of_max_rate; static while enabled
- `strobe_in`  in  1  low-rate sample strobe, one per R `strobe_out`
- `strobe_out`  in  1  high-rate output strobe
- `signal_in`  in  bw  input sample, valid when `strobe_in` high
- `signal_out`  out  bw  output sample, registered; reset value 0

## Operation
- Input sign-extended to W bits; all arithmetic modulo 2^W (wrap is intentional and harmless by CIC property).
- Comb section, updates only on `strobe_in`: diff[0] <= x; comb[0] <= x - diff[0]; for k ≥ 1: diff[k] <= comb[k-1]; comb[k] <= comb[k-1] - diff[k].
- Hold register `hold` (W bits): on `strobe_in` loads comb[N-1] (pre-update value); on `strobe_out` without `strobe_in`, cleared to 0 after use (zero-stuffing).
- Integrator section, updates only on `strobe_out`: integ[0] <= integ[0] + hold; integ[k] <= integ[k] + integ[k-1].
- Simultaneous `strobe_in` and `strobe_out`: integrator consumes the current (pre-update) `hold`; `hold` then takes the new comb value (load wins over clear).
- Gain shift s = smallest integer with 2^s ≥ R^(N-1); output = integ[N-1][s+bw-1 : s], truncation (no rounding, no saturation).
- `reset` or `enable` low: diff, comb, hold, integ, `signal_out` all 0 next cycle; mid-stream reset drops all in-flight samples, no residual output.
- R outside 1..2^log2_of_max_rate: undefined output, no lock-up.

## Timing
- `signal_out` registered every clock from shifter output: 1 clock after integ[N-1] changes.
- Sample accepted at `strobe_in` k reaches comb[N-1] at `strobe_in` k+N-1, enters `hold` at `strobe_in` k+N, first affects integ[0] at the next `strobe_out`, integ[N-1] N-1 `strobe_out`s later, `signal_out` one clock after that.
- No backpressure; strobes are externally paced; missing/extra `strobe_in` relative to R produces wrong gain but no hang.

## Structure
- Shared package/include: width function W(bw,N,log2_of_max_rate) and the shift-amount function s(R,N), reused by the decimator-side shifter.
- One sub-module: `cic_int_shifter` — combinational R→s lookup and bit-slice of integ[N-1] to bw bits.
- Comb and integrator chains as generate loops in the top.

## Test plan
- DC, bw=16, N=4, R=4: `signal_in`=1000 constant -> after settling `signal_out`=1000 every `strobe_out` (gain 64, s=6).
- DC, R=5: `signal_in`=1000 -> steady `signal_out`=976 (gain 125, s=7, truncation).
- Impulse, R=4: single `signal_in`=4096 then zeros -> nonzero output spans exactly N*R-(R-1)=13 `strobe_out`s, coefficient sum ×4096/64 = 4096·4 total, then returns to 0.
- Full-scale -32768 constant, R=128 -> internal wrap, `signal_out` settles to -32768, no glitch.
- `strobe_in` coincident with `strobe_out` vs offset by 1 clock -> identical output sequences (shifted only in time).
- `reset` pulse mid-stream (and separately `enable` low 1 cycle) -> `signal_out`=0 next cycle, all-zero output until new nonzero input propagates.
